// File: rtl/key_cond_pkg.sv
// Shared types and constants for the push-button conditioner.
package key_cond_pkg;

  localparam int HOLD_W = 16;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  function automatic int cyc_per_ms(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic int db_cycles(input int clk_hz, input int debounce_ms);
    return cyc_per_ms(clk_hz) * debounce_ms;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Multi-flop synchronizer for the asynchronous key pin. Resets to 1 so an
// active-low button reads as released while in reset.
module key_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // shift the raw pin through the synchronizer chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_conditioner.sv
// Push-button front end: synchronizes and debounces the active-low key,
// emits press/release strobes, a saturating ms hold counter and a
// long-press strobe. Optional feature macro KEY_COND_GLITCH_CNT_EN adds a
// saturating count of rejected bounces on glitch_cnt_o.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_MS     = 1000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              key_n_i,
  output logic              key_level_o,
  output logic              press_o,
  output logic              release_o,
  output logic [HOLD_W-1:0] hold_ms_o,
  output logic              long_press_o
`ifdef KEY_COND_GLITCH_CNT_EN
  ,
  output logic [7:0]        glitch_cnt_o
`endif
);

  localparam int CYC_PER_MS = cyc_per_ms(CLK_HZ);
  localparam int DB_CYC     = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int DB_W       = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int PS_W       = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CYC_PER_MS - 1);
  // long_press is only reachable when HOLD_MS fits the counter and is not 0
  localparam bit LP_EN = (HOLD_MS >= 1) && (HOLD_MS <= 65535);
  localparam logic [HOLD_W-1:0] LP_PRE = HOLD_W'(LP_EN ? HOLD_MS - 1 : 0);

  logic key_n_sync;
  logic ks;

  key_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .d_i   (key_n_i),
    .q_o   (key_n_sync)
  );

  assign ks = ~key_n_sync;

  key_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_q, db_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              lvl_q, lvl_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              lp_q, lp_d;

  // next-state: hold timing while the level is high, then debounce FSM
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    ps_d    = ps_q;
    hold_d  = hold_q;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    lp_d    = 1'b0;

    // prescaler and hold counter run in PRESSED and RELEASE_WAIT, including
    // the edge that accepts the release
    if (lvl_q) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        if (hold_q != '1) hold_d = hold_q + 1'b1;
        if (LP_EN && hold_q == LP_PRE) lp_d = 1'b1;
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end

    case (state_q)
      RELEASED: begin
        if (ks) begin
          state_d = PRESS_WAIT;
          db_d    = '0;
        end
      end
      PRESS_WAIT: begin
        if (!ks) begin
          state_d = RELEASED;
        end else if (db_q == DB_LAST) begin
          state_d = PRESSED;
          lvl_d   = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
          ps_d    = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!ks) begin
          state_d = RELEASE_WAIT;
          db_d    = '0;
        end
      end
      RELEASE_WAIT: begin
        if (ks) begin
          state_d = PRESSED;
        end else if (db_q == DB_LAST) begin
          state_d = RELEASED;
          lvl_d   = 1'b0;
          rel_d   = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RELEASED;
      db_q    <= '0;
      ps_q    <= '0;
      hold_q  <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      lp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      ps_q    <= ps_d;
      hold_q  <= hold_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      lp_q    <= lp_d;
    end
  end

  assign key_level_o  = lvl_q;
  assign press_o      = press_q;
  assign release_o    = rel_q;
  assign hold_ms_o    = hold_q;
  assign long_press_o = lp_q;

`ifdef KEY_COND_GLITCH_CNT_EN
  logic       bounce;
  logic [7:0] glitch_q;

  assign bounce = ((state_q == PRESS_WAIT) && !ks) ||
                  ((state_q == RELEASE_WAIT) && ks);

  // saturating count of bounces rejected by either wait state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                           glitch_q <= '0;
    else if (bounce && glitch_q != 8'hFF)  glitch_q <= glitch_q + 8'd1;
  end

  assign glitch_cnt_o = glitch_q;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner. Channel 0 uses slow-clock params
// (10 cycles/ms, 20-cycle debounce); channel 1 uses 1 cycle/ms so hold_ms
// saturation is reachable in a short run.
`timescale 1ns/1ps
module tb_key_conditioner;

  localparam int SYNC = 2;
  localparam int HOLD = 5;

  typedef struct {
    int kind;   // 0 press, 1 release, 2 long_press
    int cyc;
    int hold;
    int gl;
  } ev_t;

  logic clk = 1'b0;
  int   cyc = 0;
  logic rst0, rst1, key_n0, key_n1;
  wire  [1:0] rst   = {rst1, rst0};
  wire  [1:0] key_n = {key_n1, key_n0};
  logic [1:0] lvl_o, prs_o, rel_o, lp_o;
  logic [1:0][15:0] hold_o;
`ifdef KEY_COND_GLITCH_CNT_EN
  logic [1:0][7:0] gl_o;
`endif
  int   checks = 0;
  int   errors = 0;
  bit   ch1_done = 1'b0;

  key_conditioner #(.CLK_HZ(10000), .DEBOUNCE_MS(2), .SYNC_STAGES(SYNC), .HOLD_MS(HOLD)) dut0 (
    .clk_i(clk), .reset_i(rst0), .key_n_i(key_n0),
    .key_level_o(lvl_o[0]), .press_o(prs_o[0]), .release_o(rel_o[0]),
    .hold_ms_o(hold_o[0]), .long_press_o(lp_o[0])
`ifdef KEY_COND_GLITCH_CNT_EN
    , .glitch_cnt_o(gl_o[0])
`endif
  );

  key_conditioner #(.CLK_HZ(1000), .DEBOUNCE_MS(2), .SYNC_STAGES(SYNC), .HOLD_MS(HOLD)) dut1 (
    .clk_i(clk), .reset_i(rst1), .key_n_i(key_n1),
    .key_level_o(lvl_o[1]), .press_o(prs_o[1]), .release_o(rel_o[1]),
    .hold_ms_o(hold_o[1]), .long_press_o(lp_o[1])
`ifdef KEY_COND_GLITCH_CNT_EN
    , .glitch_cnt_o(gl_o[1])
`endif
  );

  // cyc is bumped just before each rising edge so it is stable all cycle
  initial forever begin
    #5 clk = 1'b0;
    #5 cyc++;
    clk = 1'b1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar c = 0; c < 2; c++) begin : g_ch
    localparam int CPM = (c == 0) ? 10 : 1;
    localparam int DB  = CPM * 2;

    ev_t q[$];
    bit  sh[SYNC];
    bit  lvl;
    int  run, pcyc, ehold, egl;
    int  np = 0, nr = 0, nl = 0;

    // reference: a level flips once DB+1 consecutive synchronized samples
    // disagree with it; hold = elapsed cycles since press / cycles-per-ms
    always @(posedge clk or posedge rst[c]) begin : model
      bit ks;
      bit fire_long;
      int el;
      if (rst[c]) begin
        q.delete();
        foreach (sh[i]) sh[i] = 1'b0;
        lvl = 1'b0; run = 0; pcyc = 0; ehold = 0; egl = 0;
      end else begin
        ks = sh[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = !key_n[c];
        fire_long = 1'b0;
        if (lvl) begin
          el = cyc - pcyc;
          ehold = (el / CPM > 65535) ? 65535 : el / CPM;
          fire_long = (el == HOLD * CPM);
        end
        if (ks != lvl) run++;
        else begin
          if (run > 0 && egl < 255) egl++;
          run = 0;
        end
        if (fire_long) q.push_back('{2, cyc, ehold, egl});
        if (run == DB + 1) begin
          lvl = !lvl;
          run = 0;
          if (lvl) begin
            pcyc = cyc;
            ehold = 0;
            q.push_back('{0, cyc, 0, egl});
          end else begin
            q.push_back('{1, cyc, ehold, egl});
          end
        end
      end
    end

    task automatic pop_chk(input int kind);
      ev_t e;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ch%0d unexpected_strobe kind=%0d actual=strobe expected=none (cycle %0d)", c, kind, cyc);
      end else begin
        e = q.pop_front();
        chk($sformatf("ch%0d_ev_kind", c), kind, e.kind);
        chk($sformatf("ch%0d_ev_cycle", c), cyc, e.cyc);
        chk($sformatf("ch%0d_ev_hold", c), hold_o[c], e.hold);
`ifdef KEY_COND_GLITCH_CNT_EN
        chk($sformatf("ch%0d_ev_glitch", c), gl_o[c], e.gl);
`endif
      end
    endtask

    // monitor: pop one expected event per DUT strobe, flag missed events
    always @(negedge clk) begin
      if (!rst[c]) begin
        np += int'(prs_o[c]);
        nr += int'(rel_o[c]);
        nl += int'(lp_o[c]);
        if (prs_o[c] || rel_o[c])
          chk($sformatf("ch%0d_press_release_excl", c), prs_o[c] & rel_o[c], 0);
        if (prs_o[c] || lp_o[c])
          chk($sformatf("ch%0d_press_long_excl", c), prs_o[c] & lp_o[c], 0);
        if (lp_o[c])  pop_chk(2);
        if (rel_o[c]) pop_chk(1);
        if (prs_o[c]) pop_chk(0);
        while (q.size() > 0 && q[0].cyc <= cyc) begin
          checks++; errors++;
          $display("FAIL ch%0d missed_event kind=%0d actual=none expected_cycle=%0d (cycle %0d)",
                   c, q[0].kind, q[0].cyc, cyc);
          void'(q.pop_front());
        end
        if (cyc % 61 == 0) begin
          chk($sformatf("ch%0d_level", c), lvl_o[c], lvl);
          chk($sformatf("ch%0d_hold", c), hold_o[c], ehold);
        end
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobe(input bit rel, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (rel ? rel_o[0] : prs_o[0]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL wait_%s timeout actual=none expected=strobe within %0d cycles",
               rel ? "release" : "press", maxc);
      at = cyc;
    end
  endtask

  // channel 1: hold long enough for hold_ms to saturate
  initial begin
    key_n1 = 1'b1;
    wait (rst1 === 1'b0);
    cyc_wait(5);
    key_n1 = 1'b0;
    cyc_wait(70000);
    chk("sat_level", lvl_o[1], 1);
    chk("sat_hold", hold_o[1], 65535);
    chk("sat_long_once", g_ch[1].nl, 1);
    key_n1 = 1'b1;
    cyc_wait(20);
    chk("sat_released", lvl_o[1], 0);
    chk("sat_hold_frozen", hold_o[1], 65535);
    ch1_done = 1'b1;
  end

  // channel 0: directed scenarios then randomized bouncing
  initial begin
    int fall, at, p_at, r_at, n0;
    rst0 = 1'b1; rst1 = 1'b1; key_n0 = 1'b1;
    cyc_wait(4);
    chk("rst_level", lvl_o[0], 0);
    chk("rst_press", prs_o[0], 0);
    chk("rst_release", rel_o[0], 0);
    chk("rst_long", lp_o[0], 0);
    chk("rst_hold", hold_o[0], 0);
    chk("rst_ch1_level", lvl_o[1], 0);
`ifdef KEY_COND_GLITCH_CNT_EN
    chk("rst_glitch", gl_o[0], 0);
`endif
    rst0 = 1'b0; rst1 = 1'b0;
    cyc_wait(10);

    // clean press: strobe SYNC+DB_CYC = 22 cycles after first sampling edge
    key_n0 = 1'b0; fall = cyc + 1;
    wait_strobe(1'b0, 60, p_at);
    chk("press_latency", p_at - fall, 22);
    chk("press_hold_zero", hold_o[0], 0);
    n0 = g_ch[0].nl;
    cyc_wait(60);
    chk("press_level", lvl_o[0], 1);
    chk("hold_at_60", hold_o[0], 6);
    chk("long_press_once", g_ch[0].nl - n0, 1);
    cyc_wait(80);

    // release bounce: 10 cycles high never qualifies
    n0 = g_ch[0].nr;
    key_n0 = 1'b1; cyc_wait(10); key_n0 = 1'b0; cyc_wait(40);
    chk("rel_bounce_level", lvl_o[0], 1);
    chk("rel_bounce_no_release", g_ch[0].nr - n0, 0);

    // clean release, hold frozen at elapsed/10 afterwards
    key_n0 = 1'b1; fall = cyc + 1;
    wait_strobe(1'b1, 60, r_at);
    chk("release_latency", r_at - fall, 22);
    cyc_wait(30);
    chk("release_level", lvl_o[0], 0);
    chk("hold_frozen", hold_o[0], (r_at - p_at) / 10);

    // press bounce: 15-cycle pulse rejected, press follows final fall
    n0 = g_ch[0].np;
    key_n0 = 1'b0; cyc_wait(15); key_n0 = 1'b1; cyc_wait(3);
    key_n0 = 1'b0; fall = cyc + 1;
    wait_strobe(1'b0, 60, at);
    chk("bounce_press_latency", at - fall, 22);
    cyc_wait(1);
    chk("bounce_single_press", g_ch[0].np - n0, 1);
`ifdef KEY_COND_GLITCH_CNT_EN
    // one rejected release bounce earlier plus this rejected press bounce
    chk("glitch_cnt", gl_o[0], 2);
`endif

    // async reset while pressed, key still held: must re-qualify
    cyc_wait(30);
    #2 rst0 = 1'b1;
    #1;
    chk("midrst_level", lvl_o[0], 0);
    chk("midrst_hold", hold_o[0], 0);
    chk("midrst_press", prs_o[0], 0);
    chk("midrst_release", rel_o[0], 0);
    chk("midrst_long", lp_o[0], 0);
    cyc_wait(2);
    rst0 = 1'b0; fall = cyc + 1;
    wait_strobe(1'b0, 60, at);
    chk("midrst_repress_latency", at - fall, 22);
    chk("midrst_hold_restart", hold_o[0], 0);
    cyc_wait(40);

    // randomized bouncing, checked entirely by the scoreboard
    key_n0 = 1'b1;
    cyc_wait(40);
    for (int i = 0; i < 60; i++) begin
      key_n0 = 1'($urandom_range(0, 1));
      cyc_wait($urandom_range(1, 50));
    end
    key_n0 = 1'b1;
    cyc_wait(60);
    chk("ch0_released_at_end", lvl_o[0], 0);

    for (int i = 0; i < 80000 && !ch1_done; i++) @(negedge clk);
    if (!ch1_done) begin
      checks++; errors++;
      $display("FAIL ch1_timeout actual=not_done expected=done");
    end
    chk("ch0_queue_empty", g_ch[0].q.size(), 0);
    chk("ch1_queue_empty", g_ch[1].q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
